// File: rtl/y_mul_div_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// operation codes and the iteration-counter width helper.
package y_mul_div_seq_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/yArith.sv
// Add/subtract stage: ctrl=0 gives a+b, ctrl=1 gives a-b as a+~b+1.
// For subtraction cout=1 means no borrow (a >= b).
module yArith #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff     = ctrl ? ~b : b;
  assign {cout, z} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ctrl};

endmodule

// File: rtl/y_mul_div_ctrl.sv
// Sequencing FSM for the multiply/divide unit: accepts a request in IDLE,
// runs WIDTH single-bit iterations, then pulses done for one cycle.
module y_mul_div_ctrl
  import y_mul_div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   div_zero,
  output logic   busy,
  output logic   done,
  output logic   load,
  output logic   step,
  output state_e state_o
);

  localparam int CW = cnt_width(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          // A zero divisor has a fixed answer, so skip the iterations.
          if (div_zero) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        step  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/y_mul_div_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle, sharing a single add/sub stage. Results are left in hi/lo.
module y_mul_div_seq
  import y_mul_div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             op_q, op_d, dbz_q, dbz_d;
  logic             load, step, div_zero;
  logic [WIDTH-1:0] add_a, add_z;
  logic             add_cout, rem_msb, take;
  state_e           ctrl_state;

  assign div_zero = (op == OP_DIV) && (b == '0);

  y_mul_div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .div_zero (div_zero),
    .busy     (busy),
    .done     (done),
    .load     (load),
    .step     (step),
    .state_o  (ctrl_state)
  );

  // Divide works on the remainder shifted left by one with the next dividend
  // bit; hi[W-1] is the 33rd remainder bit lost by that shift.
  assign rem_msb = hi_q[WIDTH-1];
  assign add_a   = (op_q == OP_DIV) ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : hi_q;
  assign take    = rem_msb | add_cout;

  yArith #(.WIDTH(WIDTH)) u_arith (
    .a    (add_a),
    .b    (b_q),
    .ctrl (op_q),
    .z    (add_z),
    .cout (add_cout)
  );

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    op_d  = op_q;
    dbz_d = dbz_q;
    if (load) begin
      op_d = op;
      b_d  = b;
      if (div_zero) begin
        hi_d  = a;
        lo_d  = '1;
        dbz_d = 1'b1;
      end else begin
        hi_d  = '0;
        lo_d  = a;
        dbz_d = 1'b0;
      end
    end else if (step && (ctrl_state == ST_RUN)) begin
      if (op_q == OP_MUL) begin
        if (lo_q[0]) begin
          hi_d = {add_cout, add_z[WIDTH-1:1]};
          lo_d = {add_z[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
      end else begin
        if (take) begin
          hi_d = add_z;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = add_a;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      op_q  <= op_d;
      dbz_q <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/y_mul_div_seq.md
Name: y_mul_div_seq

Overview:
- Iterative unsigned multiply/divide unit, one bit per cycle.
- Sits directly on the 32-bit add/sub stage: drives its a/b/ctrl every cycle and consumes z/cout.
- ctrl=0 (add) for shift-add multiply; ctrl=1 (subtract) for restoring divide.
- Results land in hi/lo registers and are read by the writeback path.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = multiply, 1 = divide.
- a  input  WIDTH  multiplicand / dividend, captured at accept.
- b  input  WIDTH  multiplier / divisor, captured at accept.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when hi/lo are valid.
- hi  output  WIDTH  mul: product[2W-1:W]; div: remainder.
- lo  output  WIDTH  mul: product[W-1:0]; div: quotient.
- div_by_zero  output  1  sticky until next accept; set when divide with b==0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - state=IDLE; busy=0, done=0, div_by_zero=0.
  - hi=0, lo=0, iteration counter=0.
  - op and b capture registers = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> capture op and b; clear div_by_zero.
  - mul: hi=0, lo=a. div: hi=0 (remainder), lo=a (dividend/quotient shift register), rem_msb=0.
  - count=WIDTH; go to RUN.
  - Exception: divide with b==0 loads hi=a, lo={WIDTH{1}}, div_by_zero=1 and goes straight to DONE.
- RUN, one iteration per cycle, count decrements; leave to DONE on the cycle count reaches 1.
- Multiply step (adder ctrl=0, a=hi, b=captured b):
  - If lo[0]=1: {hi,lo} <= {cout, z, lo[W-1:1]}.
  - Else: {hi,lo} <= {1'b0, hi, lo[W-1:1]}.
- Divide step (adder ctrl=1, a={hi[W-2:0],lo[W-1]}, b=captured b):
  - rem_msb = hi[W-1] (the 33rd remainder bit).
  - If rem_msb | cout: hi <= z, lo <= {lo[W-2:0],1}.
  - Else: hi <= {hi[W-2:0],lo[W-1]}, lo <= {lo[W-2:0],0}.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE.
- Latency: accept edge + WIDTH RUN cycles + 1 DONE cycle. done is high in cycle WIDTH+1 after the accept edge (33 for WIDTH=32). Divide-by-zero: done in cycle 1.
- hi/lo/div_by_zero hold their values in IDLE until the next accept.
- start while busy: ignored, no effect on state or results.
- start held high continuously: re-accepted in the IDLE cycle after DONE. Back-to-back throughput is WIDTH+2 cycles.
- a/b changes after accept: no effect; the operands are captured.
- rst_n low mid-operation: immediate return to reset values; no done pulse.
- All arithmetic is unsigned and modulo 2^WIDTH per adder pass. The 2W-bit product is exact.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - OP_MUL=1'b0, OP_DIV=1'b1.
  - Counter width = clog2(WIDTH)+1.
- Datapath instantiates the existing 32-bit add/sub unit yArith once; it is shared by both ops, and ctrl=captured op.
- One natural sub-module: y_mul_div_ctrl (FSM + counter, outputs busy/done/load/step). The top holds the hi/lo/b registers and the step muxing.

Test Plan:
- mul a=7, b=6 -> done exactly 33 cycles after accept; hi=0x00000000, lo=0x0000002A; busy high for cycles 1..33.
- mul a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Checks the cout path into hi.
- div a=100, b=7 -> lo=14, hi=2. div a=0xFFFFFFFF, b=0x80000000 -> lo=1, hi=0x7FFFFFFF. Checks rem_msb handling.
- div a=5, b=0 -> done in cycle 1; lo=0xFFFFFFFF, hi=5, div_by_zero=1. Next accepted mul 3*4 clears div_by_zero; lo=12.
- start pulsed with new operands at cycle 10 of a running mul 7*6 -> ignored; result still hi=0, lo=42. start held high -> second accept occurs the cycle after done.
- rst_n asserted at cycle 15 of a divide -> busy, done, hi, lo all 0 asynchronously; no done pulse. A fresh div 9/3 after release gives lo=3, hi=0.
